keypad_matrix_scanner: RTL
==========================

Name: keypad_matrix_scanner

Overview:
- Scans a 4x4 membrane keypad on the input side of the board I/O.
- Drives one column low at a time and samples the four row lines.
- Debounces the result over whole scans and reports each confirmed press as a position code plus a one-cycle valid pulse.
- Sits beside the seven-segment display driver; its key_code normally feeds the digit registers that the display driver shows.

Parameters:
- SCAN_PERIOD, 100000: clk cycles each column is driven before its rows are sampled (minimum 4).
- DEBOUNCE_SCANS, 4: consecutive full scans that must agree before a press or release is accepted (minimum 1).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- row  in  4  keypad row lines; active low, externally pulled up; asynchronous to clk.
- col  out  4  column drive; exactly one bit low while out of reset.
- key_code  out  4  position code of the last confirmed press = row_idx*4 + col_idx.
- key_valid  out  1  one-cycle pulse when a press is confirmed.
- key_down  out  1  high while a confirmed key is held.

Behaviour:
- Interface (already decided): one clock, clk; reset is synchronous and active-high, port name reset.
- Reset values: col=4'b1110, key_code=0, key_valid=0, key_down=0, state=IDLE. Tick counter, column index and scan accumulator are 0; row synchronizer flops are 4'b1111.
- Row input passes through a 2-flop synchronizer before use.
- Tick counter runs 0..SCAN_PERIOD-1; tick=1 when the count is SCAN_PERIOD-1, then it wraps to 0.
- On tick:
  - Sample the synchronized rows for the current col_idx.
  - Advance col_idx modulo 4.
  - Column pattern by col_idx: 0->1110, 1->1101, 2->1011, 3->0111.
- Scan result: the first pressed key in col-major order (lowest col_idx, then lowest row_idx); "none" if no row is low.
  - Multiple simultaneous keys: the lowest position in that order wins.
  - No ghost rejection.
- Evaluation happens on the col_idx==3 tick, using the accumulated result plus that tick's sample in the same cycle. The accumulator then clears.
- FSM, advanced only on evaluation ticks; cnt counts agreeing scans:
  - IDLE:
    - key K -> PRESS_CONFIRM, cand=K, cnt=1.
    - If DEBOUNCE_SCANS==1, go straight to HELD with the HELD entry actions.
  - PRESS_CONFIRM:
    - Same K -> cnt+1; on reaching DEBOUNCE_SCANS go to HELD: key_code<=cand, key_valid=1 for one cycle, key_down<=1.
    - Different key -> restart with cand=new key, cnt=1.
    - None -> IDLE.
  - HELD:
    - Any key, same or different, stays HELD. No new press is reported until release (no rollover).
    - None -> RELEASE_CONFIRM, cnt=1; if DEBOUNCE_SCANS==1, go directly to IDLE with key_down<=0.
  - RELEASE_CONFIRM:
    - None -> cnt+1; on reaching DEBOUNCE_SCANS go to IDLE with key_down<=0.
    - Any key -> HELD, key_down stays 1.
- key_code holds its value after release and changes only on a confirmed press.
- Latency:
  - key_valid rises on the evaluation tick of the DEBOUNCE_SCANS-th agreeing scan, registered that edge.
  - Worst case from the row edge: (DEBOUNCE_SCANS+1)*4*SCAN_PERIOD + 2 cycles.
- Reset asserted mid-scan or mid-confirm returns every register to its reset value on the next edge. No pulse is emitted in that cycle.

Decomposition:
- Package keypad_pkg holds:
  - scan_state_t enum {IDLE, PRESS_CONFIRM, HELD, RELEASE_CONFIRM};
  - COL_PATTERN[0:3] constants;
  - KEY_HEX[0:15] table mapping position code to keypad legend: 1,2,3,A / 4,5,6,B / 7,8,9,C / 0,F,E,D by row. The table is used by consumers, not by this block.
- One sub-module: scan_tick_gen (parameterised SCAN_PERIOD, synchronous reset, one-cycle tick enable). Do not use a derived clock.

Test Plan (SCAN_PERIOD=4, DEBOUNCE_SCANS=3, so one scan = 16 clocks):
- Reset: assert reset 3 cycles -> col=1110, key_code=0, key_valid=0, key_down=0. After release, col sequence 1110,1101,1011,0111 with 4 clocks per pattern, wrapping.
- Clean press: hold row[2] low only while col=1011 (row 2, col 2) -> exactly one key_valid pulse after the 3rd agreeing scan, key_code=10, key_down=1. Release -> key_down=0 after 3 empty scans, key_code still 10.
- Bounce: press position 5 for 1 scan, release for 1 scan, press for 3 scans -> one key_valid only, key_code=5. No pulse from the first bounce.
- Candidate change: position 1 for 2 scans, then position 6 for 3 scans -> single key_valid with key_code=6.
- Held and release glitch: hold position 0 for 10 scans with one empty scan in the middle -> one key_valid, key_down stays 1 throughout. Two keys (positions 4 and 9) pressed together -> code 4 reported.
- Reset mid-confirm: reset asserted during PRESS_CONFIRM at cnt=2 -> no key_valid. Press resumed after reset needs 3 fresh scans before key_valid.

Source files
------------

// File: rtl/keypad_matrix_scanner_pkg.sv
// Shared types and constants for the 4x4 keypad matrix scanner and its consumers.
package keypad_pkg;

  typedef enum logic [1:0] {
    IDLE            = 2'd0,
    PRESS_CONFIRM   = 2'd1,
    HELD            = 2'd2,
    RELEASE_CONFIRM = 2'd3
  } scan_state_t;

  // Column drive pattern indexed by column number; exactly one line pulled low.
  localparam logic [3:0] COL_PATTERN [0:3] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

  // Keypad legend for each position code (row_idx*4 + col_idx), for display consumers.
  localparam logic [3:0] KEY_HEX [0:15] = '{
    4'h1, 4'h2, 4'h3, 4'hA,
    4'h4, 4'h5, 4'h6, 4'hB,
    4'h7, 4'h8, 4'h9, 4'hC,
    4'h0, 4'hF, 4'hE, 4'hD
  };

  // Position code of a key from its row and column index.
  function automatic logic [3:0] pos_code(input logic [1:0] row_idx, input logic [1:0] col_idx);
    return {row_idx, col_idx};
  endfunction

endpackage

// File: rtl/keypad_matrix_scanner_scan_tick_gen.sv
// Free-running divider producing a one-cycle tick enable every SCAN_PERIOD clocks.
module scan_tick_gen #(
  parameter int SCAN_PERIOD = 100000
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int CW = (SCAN_PERIOD < 2) ? 1 : $clog2(SCAN_PERIOD);
  localparam logic [CW-1:0] LAST = CW'(SCAN_PERIOD - 1);

  logic [CW-1:0] count;

  assign tick = (count == LAST);

  // Count 0..SCAN_PERIOD-1 and wrap on the tick cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (tick) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/keypad_matrix_scanner.sv
// 4x4 keypad scanner: walks a low column across the matrix, samples the rows,
// debounces whole-scan results and reports confirmed presses.
module keypad_matrix_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_PERIOD    = 100000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_down
);

  localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [CNT_W-1:0] CNT_TARGET = CNT_W'(DEBOUNCE_SCANS);

  logic [3:0]       row_meta;
  logic [3:0]       row_sync;
  logic             tick;
  logic [1:0]       col_idx;
  logic             acc_found;
  logic [3:0]       acc_code;
  logic             sample_found;
  logic [1:0]       sample_row;
  logic [3:0]       sample_code;
  logic             eval;
  logic             scan_found;
  logic [3:0]       scan_code;
  scan_state_t      state;
  scan_state_t      state_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic [CNT_W-1:0] cnt_inc;
  logic [3:0]       cand;
  logic [3:0]       cand_next;
  logic [3:0]       key_code_next;
  logic             key_down_next;
  logic             key_valid_next;

  scan_tick_gen #(
    .SCAN_PERIOD(SCAN_PERIOD)
  ) u_tick (
    .clk  (clk),
    .reset(reset),
    .tick (tick)
  );

  assign col = COL_PATTERN[col_idx];

  // Two-flop synchronizer; the idle (pulled-up) level is all ones.
  always_ff @(posedge clk) begin
    if (reset) begin
      row_meta <= 4'hF;
      row_sync <= 4'hF;
    end else begin
      row_meta <= row;
      row_sync <= row_meta;
    end
  end

  // Step to the next column on each tick, wrapping after column 3.
  always_ff @(posedge clk) begin
    if (reset) begin
      col_idx <= 2'd0;
    end else if (tick) begin
      col_idx <= col_idx + 2'd1;
    end
  end

  // Lowest pressed row in the currently driven column.
  always_comb begin
    sample_found = 1'b0;
    sample_row   = 2'd0;
    for (int r = 3; r >= 0; r--) begin
      if (!row_sync[r]) begin
        sample_found = 1'b1;
        sample_row   = 2'(r);
      end
    end
  end

  assign sample_code = pos_code(sample_row, col_idx);
  assign eval        = tick && (col_idx == 2'd3);

  // The accumulator keeps the first key found this scan; columns come in
  // ascending order, so the first hit is also the lowest column.
  assign scan_found = acc_found | sample_found;
  assign cnt_inc    = cnt + CNT_W'(1);
  assign scan_code  = acc_found ? acc_code : sample_code;

  // Accumulate the first hit of the scan and clear after evaluation.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_found <= 1'b0;
      acc_code  <= 4'd0;
    end else if (tick) begin
      if (col_idx == 2'd3) begin
        acc_found <= 1'b0;
        acc_code  <= 4'd0;
      end else if (!acc_found && sample_found) begin
        acc_found <= 1'b1;
        acc_code  <= sample_code;
      end
    end
  end

  // Debounce state and reported key registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      cand      <= 4'd0;
      key_code  <= 4'd0;
      key_down  <= 1'b0;
      key_valid <= 1'b0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      cand      <= cand_next;
      key_code  <= key_code_next;
      key_down  <= key_down_next;
      key_valid <= key_valid_next;
    end
  end

  // Debounce decisions, taken only when a full scan has been evaluated.
  always_comb begin
    state_next     = state;
    cnt_next       = cnt;
    cand_next      = cand;
    key_code_next  = key_code;
    key_down_next  = key_down;
    key_valid_next = 1'b0;
    if (eval) begin
      case (state)
        IDLE: begin
          if (scan_found) begin
            cand_next = scan_code;
            cnt_next  = CNT_W'(1);
            if (DEBOUNCE_SCANS == 1) begin
              state_next     = HELD;
              key_code_next  = scan_code;
              key_valid_next = 1'b1;
              key_down_next  = 1'b1;
            end else begin
              state_next = PRESS_CONFIRM;
            end
          end
        end
        PRESS_CONFIRM: begin
          if (!scan_found) begin
            state_next = IDLE;
            cnt_next   = '0;
          end else if (scan_code != cand) begin
            cand_next = scan_code;
            cnt_next  = CNT_W'(1);
          end else if (cnt_inc >= CNT_TARGET) begin
            state_next     = HELD;
            cnt_next       = '0;
            key_code_next  = cand;
            key_valid_next = 1'b1;
            key_down_next  = 1'b1;
          end else begin
            cnt_next = cnt_inc;
          end
        end
        HELD: begin
          if (!scan_found) begin
            if (DEBOUNCE_SCANS == 1) begin
              state_next    = IDLE;
              cnt_next      = '0;
              key_down_next = 1'b0;
            end else begin
              state_next = RELEASE_CONFIRM;
              cnt_next   = CNT_W'(1);
            end
          end
        end
        RELEASE_CONFIRM: begin
          if (scan_found) begin
            state_next = HELD;
            cnt_next   = '0;
          end else if (cnt_inc >= CNT_TARGET) begin
            state_next    = IDLE;
            cnt_next      = '0;
            key_down_next = 1'b0;
          end else begin
            cnt_next = cnt_inc;
          end
        end
        default: begin
          state_next = IDLE;
          cnt_next   = '0;
        end
      endcase
    end
  end

endmodule
